// File: rtl/uart_tx_from_reg_pkg.sv
// Shared definitions for the UART transmit path: defaults, FSM encodings, bit-period math.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_tx_from_reg_pkg;

    localparam int unsigned DEF_CLK_FREQ = 100_000_000;
    localparam int unsigned DEF_BAUD     = 9_600;
    localparam int unsigned DEF_WORDSZ   = 8;
    localparam int unsigned STATE_W      = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_DATA   = 4'd2,
        ST_PARITY = 4'd3,
        ST_STOP   = 4'd4
    } tx_state_e;

    // Integer-truncated clock cycles per UART bit; shared with the receive side.
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_from_reg_if.sv
// Byte handshake between the byte source (e.g. uart_to_reg BUS) and the UART transmitter.
// Optional build macro UART_TX_PARITY_EN does not affect this interface.
interface uart_tx_from_reg_if #(
    parameter int unsigned WORDSZ = 8
);
    logic [WORDSZ-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (output din, output din_valid, input  din_ready);
    modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/uart_tx_from_reg_baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, held at zero while cleared.
// Optional build macro UART_TX_PARITY_EN does not affect this module.
module uart_tx_from_reg_baud_tick
    import uart_tx_from_reg_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned CPB   = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W = cnt_width(CPB);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap   = (r_cnt == CNT_W'(CPB - 1));
    assign o_tick_c = w_wrap && !i_clr;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_from_reg.sv
// 8N1 UART transmitter fed by a valid/ready byte handshake; closes the RX->BUS->TX echo path.
// Build macro UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx_from_reg
    import uart_tx_from_reg_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD,
    parameter int unsigned WORDSZ   = DEF_WORDSZ
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    uart_tx_from_reg_if.slave    bus,
    output logic                 o_txd_pin,
    output logic                 o_busy,
    output logic [STATE_W-1:0]   o_state
);

    localparam int unsigned IDX_W = cnt_width(WORDSZ);

    tx_state_e         r_state;
    tx_state_e         w_state_next;
    logic [WORDSZ-1:0] r_data;
    logic [WORDSZ-1:0] w_data_next;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [IDX_W-1:0]  w_bit_idx_next;
    logic              r_txd;
    logic              w_txd_next;
    logic              r_busy;
    logic              w_tick;
    logic              w_baud_clr;
    logic              w_accept;
    logic              w_last_bit;

    assign bus.din_ready = (r_state == ST_IDLE);
    assign w_accept      = bus.din_valid && bus.din_ready;
    assign w_last_bit    = (r_bit_idx == IDX_W'(WORDSZ - 1));

    assign o_txd_pin = r_txd;
    assign o_busy    = r_busy;
    assign o_state   = r_state;

    uart_tx_from_reg_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_tick (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_baud_clr),
        .o_tick_c (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Each non-idle state lasts exactly one bit period, ended by the baud tick.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_START;
            ST_START: if (w_tick)   w_state_next = ST_DATA;
            ST_DATA: begin
                if (w_tick && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (w_tick) w_state_next = ST_STOP;
`endif
            ST_STOP:  if (w_tick)   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Line level is chosen from the next state so TXD changes on the same edge as STATE.
    always_comb begin
        w_data_next    = r_data;
        w_bit_idx_next = r_bit_idx;
        w_baud_clr     = 1'b0;
        w_txd_next     = 1'b1;

        case (r_state)
            ST_IDLE: begin
                w_baud_clr = 1'b1;
                if (w_accept) w_data_next = bus.din;
            end
            ST_DATA: begin
                if (w_tick) w_bit_idx_next = w_last_bit ? '0 : r_bit_idx + IDX_W'(1);
            end
            default: ;
        endcase

        case (w_state_next)
            ST_START:  w_txd_next = 1'b0;
            ST_DATA:   w_txd_next = r_data[w_bit_idx_next];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_txd_next = ^r_data;
`endif
            default:   w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data    <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_data    <= w_data_next;
            r_bit_idx <= w_bit_idx_next;
            r_txd     <= w_txd_next;
            r_busy    <= (w_state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_from_reg.sv
// Directed bench for uart_tx_from_reg: frames sampled mid-bit, handshake, reset and busy behaviour.
// Expects the even-parity bit when built with UART_TX_PARITY_EN.
module tb_uart_tx_from_reg;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned CPB      = 16;
    localparam int unsigned WORDSZ   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       txd;
    logic       busy;
    logic [3:0] state;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_tx_from_reg_if #(.WORDSZ(WORDSZ)) bus ();

    uart_tx_from_reg #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .WORDSZ   (WORDSZ)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .o_txd_pin (txd),
        .o_busy    (busy),
        .o_state   (state)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        logic [7:0] v;
        v = b;
        if (k == 0) return 1'b0;
        if (k <= 8) return v[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^v;
`endif
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_state(input int k);
        if (k == 0) return 4'd1;
        if (k <= 8) return 4'd2;
`ifdef UART_TX_PARITY_EN
        if (k == 9) return 4'd3;
`endif
        return 4'd4;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_txd"},   txd,           32'd1);
        check({tag, "_ready"}, bus.din_ready, 32'd1);
        check({tag, "_busy"},  busy,          32'd0);
        check({tag, "_state"}, state,         32'd0);
    endtask

    // Called one step after the accepting edge; samples every bit at its midpoint.
    task automatic check_frame(input logic [7:0] b, input int pulse_k);
        step(CPB / 2);
        for (int k = 0; k < NBITS; k++) begin
            check($sformatf("txd_%02h_b%0d", b, k),   txd,   32'(exp_bit(b, k)));
            check($sformatf("state_%02h_b%0d", b, k), state, 32'(exp_state(k)));
            if (k < NBITS - 1) begin
                if (k == pulse_k) begin
                    bus.din       = 8'h55;
                    bus.din_valid = 1'b1;
                    step(1);
                    bus.din_valid = 1'b0;
                    step(CPB - 1);
                end else begin
                    step(CPB);
                end
            end
        end
        step(CPB / 2 - 1);
        check($sformatf("ready_early_%02h", b), bus.din_ready, 32'd0);
        check($sformatf("busy_late_%02h", b),   busy,          32'd1);
        step(1);
        check_idle($sformatf("end_%02h", b));
    endtask

    task automatic send(input logic [7:0] b);
        check($sformatf("ready_pre_%02h", b), bus.din_ready, 32'd1);
        bus.din       = b;
        bus.din_valid = 1'b1;
        step(1);
        bus.din_valid = 1'b0;
        check($sformatf("start_fall_%02h", b), txd,   32'd0);
        check($sformatf("start_st_%02h", b),   state, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.din       = 8'h99;
        bus.din_valid = 1'b1;

        // Reset dominates a pending byte.
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_idle($sformatf("rst%0d", i));
        end
        rst           = 1'b0;
        bus.din_valid = 1'b0;
        step(1);
        check_idle("post_rst");

        // Single byte "A".
        send(8'h41);
        check_frame(8'h41, -1);

        // Back-to-back with valid held: exactly one idle cycle between frames.
        bus.din       = 8'h00;
        bus.din_valid = 1'b1;
        step(1);
        bus.din = 8'hFF;
        check("b2b_start0", txd, 32'd0);
        check_frame(8'h00, -1);
        step(1);
        bus.din_valid = 1'b0;
        check("b2b_start1_txd",   txd,   32'd0);
        check("b2b_start1_state", state, 32'd1);
        check_frame(8'hFF, -1);

        // Valid pulse while a frame is in DATA is ignored.
        send(8'h0F);
        check_frame(8'h0F, 3);
        step(2 * CPB);
        check_idle("ignored");

        // Reset in the middle of data bit 3 of 8'hA5 (bit value 0).
        send(8'hA5);
        step(CPB / 2 + 4 * CPB);
        check("a5_bit3_txd",   txd,   32'd0);
        check("a5_bit3_state", state, 32'd2);
        rst = 1'b1;
        step(1);
        check_idle("midrst");
        rst = 1'b0;
        step(1);
        send(8'h3C);
        check_frame(8'h3C, -1);

        // Odd-parity data byte.
        send(8'h07);
        check_frame(8'h07, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
